// File: rtl/cpu_program_sequencer_pkg.sv
// Shared types and constants for the cpu program sequencer.
// State encoding, the halt word and cpu opcode fields.
package cpu_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    STRT,
    WLOW,
    WHIGH,
    NEXT,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] HALT_WORD = 16'hE000;

  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b111;

endpackage

// File: rtl/cpu_program_sequencer_ram.sv
// Instruction RAM for the program sequencer.
// Synchronous write, asynchronous read.
module seq_prog_ram #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  logic [15:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_program_sequencer.sv
// Programmable instruction feeder for the cpu.
// Issues each RAM word with load/s strobes and waits on w.
module cpu_program_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [15:0]       prog_data,
  input  logic              cpu_w,
  output logic [15:0]       cpu_in,
  output logic              cpu_load,
  output logic              cpu_s,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

  state_t        state;
  logic [TW-1:0] timer;
  logic [15:0]   mem_q;
  logic          idle_like;
  logic          ram_we;

  assign idle_like = (state == IDLE) || (state == DONE)
                  || (state == ERROR);
  assign ram_we    = prog_we && idle_like;

  seq_prog_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(prog_addr),
    .wdata(prog_data),
    .raddr(pc),
    .rdata(mem_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      cpu_in      <= '0;
      cpu_load    <= 1'b0;
      cpu_s       <= 1'b0;
      pc          <= '0;
      instr_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      cpu_load <= 1'b0;
      cpu_s    <= 1'b0;
      unique case (state)
        IDLE, DONE, ERROR: begin
          if (start && !prog_we) begin
            state       <= FETCH;
            pc          <= '0;
            instr_count <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          cpu_in <= mem_q;
          if (mem_q == HALT_WORD) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= LOAD;
            cpu_load <= 1'b1;
          end
        end
        LOAD: begin
          state <= STRT;
          cpu_s <= 1'b1;
        end
        STRT: begin
          timer <= '0;
          state <= WLOW;
        end
        WLOW: begin
          if (!cpu_w) begin
            timer <= '0;
            state <= WHIGH;
          end else if (timer == T_LAST) begin
            state <= ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WHIGH: begin
          if (cpu_w) begin
            state <= NEXT;
          end else if (timer == T_LAST) begin
            state <= ERROR;
            err   <= 1'b1;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        NEXT: begin
          if (instr_count != 8'hFF)
            instr_count <= instr_count + 8'd1;
          // last word ends the program; pc never wraps
          if (pc == PC_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            pc    <= pc + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_program_sequencer.sv
// Bench for cpu_program_sequencer with a small cpu model.
// Issued words are scoreboarded against an expected queue.
module tb_cpu_program_sequencer;
  import cpu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic        cpu_w;
  logic [15:0] cpu_in;
  logic        cpu_load;
  logic        cpu_s;
  logic [3:0]  pc;
  logic [7:0]  instr_count;
  logic        busy;
  logic        done;
  logic        err;

  cpu_program_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .cpu_w      (cpu_w),
    .cpu_in     (cpu_in),
    .cpu_load   (cpu_load),
    .cpu_s      (cpu_s),
    .pc         (pc),
    .instr_count(instr_count),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int nload    = 0;
  int ns       = 0;
  logic [15:0] expq [$];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (cpu_load || cpu_s)
      chk("strobe_excl", {31'd0, cpu_load & cpu_s}, 32'd0);
    if (cpu_s) ns++;
    if (cpu_load) begin
      nload++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected actual=%0h expected=none",
                 cpu_in);
      end else begin
        chk("issue_word", {16'd0, cpu_in},
            {16'd0, expq.pop_front()});
      end
    end
  end

  // cpu model
  logic [15:0] ir;
  logic [15:0] r [8];
  int          lat;
  bit          stuck = 1'b0;

  function automatic logic [15:0] shf(logic [15:0] x,
                                      logic [1:0] sh);
    case (sh)
      2'b01:   return {x[14:0], 1'b0};
      2'b10:   return {1'b0, x[15:1]};
      2'b11:   return {x[15], x[15:1]};
      default: return x;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cpu_w <= 1'b1;
      lat   <= 0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (cpu_s && !stuck) begin
        cpu_w <= 1'b0;
        lat   <= 2;
      end else if (!cpu_w) begin
        if (lat == 0) begin
          case (ir[15:13])
            OP_MOV:
              if (ir[12:11] == 2'b10)
                r[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
            OP_ALU:
              if (ir[12:11] == 2'b00)
                r[ir[7:5]] <= r[ir[10:8]]
                            + shf(r[ir[2:0]], ir[4:3]);
            default: ;
          endcase
          cpu_w <= 1'b1;
        end else begin
          lat <= lat - 1;
        end
      end
    end
  end

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(done || err) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("FAIL wait_end actual=timeout required=done");
    end
  endtask

  task automatic run(input int max);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(max);
  endtask

  task automatic push3();
    expq.push_back(16'hD006);
    expq.push_back(16'hD105);
    expq.push_back(16'hA148);
  endtask

  int n0, s0, cnt;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", {cpu_in, cpu_load, cpu_s, pc, instr_count,
                    busy, done, err}, 32'd0);
    reset = 1'b0;

    // start with prog_we in IDLE: write only
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'hD006;
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    @(negedge clk);
    chk("we_start_busy", {31'd0, busy}, 32'd0);
    chk("we_start_load", nload, 0);
    write(4'd1, 16'hD105);
    write(4'd2, HALT_WORD);

    // two MOVs then HALT, with strobe timing
    expq.push_back(16'hD006);
    expq.push_back(16'hD105);
    n0 = nload;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t_k1_busy", {31'd0, busy}, 32'd1);
    chk("t_k1_load", {31'd0, cpu_load}, 32'd0);
    @(negedge clk);
    chk("t_k2_ls", {30'd0, cpu_load, cpu_s}, 32'd2);
    @(negedge clk);
    chk("t_k3_ls", {30'd0, cpu_load, cpu_s}, 32'd1);
    wait_end(400);
    chk("mov_done", {30'd0, done, err}, 32'd2);
    chk("mov_count", instr_count, 2);
    chk("mov_pc", pc, 2);
    chk("mov_r0", r[0], 16'd6);
    chk("mov_r1", r[1], 16'd5);
    chk("mov_nload", nload - n0, 2);
    chk("mov_cpu_in", cpu_in, HALT_WORD);

    // ADD R2,R1,R0 LSL#1
    write(4'd2, 16'hA148);
    write(4'd3, HALT_WORD);
    push3();
    run(400);
    chk("add_r2", r[2], 16'h0011);
    chk("add_count", instr_count, 3);
    chk("add_pc", pc, 3);

    // full memory, no HALT
    for (int i = 0; i < 16; i++) begin
      write(4'(i), 16'hD717);
      expq.push_back(16'hD717);
    end
    n0 = nload;
    run(2000);
    chk("fill_de", {30'd0, done, err}, 32'd2);
    chk("fill_pc", pc, 15);
    chk("fill_count", instr_count, 16);
    chk("fill_nload", nload - n0, 16);
    chk("fill_r7", r[7], 16'd23);

    // stuck cpu: handshake timeout
    write(4'd0, 16'hD006);
    write(4'd1, HALT_WORD);
    stuck = 1'b1;
    expq.push_back(16'hD006);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!cpu_s && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (!err && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cycles", cnt, 65);
    chk("to_err", {29'd0, err, busy, done}, 32'd4);
    n0 = nload;
    s0 = ns;
    repeat (10) @(negedge clk);
    chk("to_quiet", {nload - n0, ns - s0}, 32'd0);
    stuck = 1'b0;
    expq.push_back(16'hD006);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("to_restart", {30'd0, err, busy}, 32'd1);
    wait_end(400);
    chk("to_rerun", {instr_count, 6'd0, done, err}, {8'd1, 8'd2});

    // reset during WHIGH
    write(4'd1, 16'hD105);
    write(4'd2, 16'hA148);
    write(4'd3, HALT_WORD);
    push3();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (cpu_w && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    chk("wh_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("wh_rst_out", {cpu_in, cpu_load, cpu_s, pc, instr_count,
                       busy, done, err}, 32'd0);
    reset = 1'b0;
    expq.delete();
    push3();
    run(400);
    chk("wh_rerun_r", {r[0][7:0], r[1][7:0], r[2][7:0]},
        32'h060511);
    chk("wh_rerun_count", instr_count, 3);

    // prog_we and start while busy are ignored
    push3();
    n0 = nload;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 4'd0;
    prog_data = 16'hD0FF;
    start     = 1'b1;
    @(negedge clk);
    prog_we = 1'b0;
    start   = 1'b0;
    wait_end(400);
    chk("busy_nload", nload - n0, 3);
    chk("busy_count", instr_count, 3);
    push3();
    run(400);
    chk("busy_r0", r[0], 16'd6);
    chk("q_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
